// File: rtl/vram_scanout.sv
// vram_scanout: 640x480 VGA timing generator and 1-bpp frame streamer.
// Each VRAM row is prefetched during the previous line's horizontal blanking
// into fetch_buf, then swapped into line_buf at the end of that line.
// Ports:
//   clk, rst         - system clock, synchronous active-high reset
//   pix_en           - pixel strobe, one pixel period per clk with pix_en=1
//   vram_rd_addr/_en - VRAM row read request (addr held between fetches)
//   from_vram_read   - VRAM row data, valid RD_LATENCY clks after the request
//   pixel            - current pixel, 0 outside the active area
//   hsync, vsync     - active-low sync pulses
//   video_on, vblank - active-area / vertical-blanking status
//   frame_start      - one-clk pulse on the step into (h=0, v=0)
module vram_scanout #(
    parameter int unsigned H_ACTIVE   = 640,
    parameter int unsigned H_FP       = 16,
    parameter int unsigned H_SYNC     = 96,
    parameter int unsigned H_BP       = 48,
    parameter int unsigned V_ACTIVE   = 480,
    parameter int unsigned V_FP       = 10,
    parameter int unsigned V_SYNC     = 2,
    parameter int unsigned V_BP       = 33,
    parameter int unsigned RD_LATENCY = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                pix_en,
    output logic [8:0]          vram_rd_addr,
    output logic                vram_rd_en,
    input  logic [H_ACTIVE-1:0] from_vram_read,
    output logic                pixel,
    output logic                hsync,
    output logic                vsync,
    output logic                video_on,
    output logic                vblank,
    output logic                frame_start
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HW      = $clog2(H_TOTAL);
    localparam int unsigned VW      = $clog2(V_TOTAL);
    localparam int unsigned VW1     = VW + 1;
    localparam int unsigned XW      = $clog2(H_ACTIVE);
    localparam int unsigned LW      = 3;
    localparam int unsigned AW      = 9;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    logic [HW-1:0]       r_h_cnt;
    logic [VW-1:0]       r_v_cnt;
    logic                r_pixel;
    logic                r_hsync;
    logic                r_vsync;
    logic                r_video_on;
    logic                r_vblank;
    logic                r_frame_start;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [LW-1:0]       r_lat;
    logic [LW-1:0]       w_lat_nxt;
    logic                r_rd_en;
    logic                w_rd_en_nxt;
    logic [AW-1:0]       r_rd_addr;
    logic [AW-1:0]       w_rd_addr_nxt;
    logic                w_capture;

    logic [H_ACTIVE-1:0] r_fetch_buf;
    logic                r_fetch_valid;
    logic [H_ACTIVE-1:0] r_line_buf;

    logic                w_h_last;
    logic                w_v_last;
    logic                w_video_on;
    logic                w_hsync;
    logic                w_vsync;
    logic                w_vblank;
    logic [XW-1:0]       w_x;
    logic                w_pix_bit;
    logic [VW:0]         w_v_inc;
    logic                w_fetch_req;
    logic [VW:0]         w_next_row;

    // Position decode for the current (h, v)
    always_comb begin
        w_h_last    = (r_h_cnt == HW'(H_TOTAL - 1));
        w_v_last    = (r_v_cnt == VW'(V_TOTAL - 1));
        w_video_on  = (r_h_cnt < HW'(H_ACTIVE)) && (r_v_cnt < VW'(V_ACTIVE));
        w_hsync     = !((r_h_cnt >= HW'(H_ACTIVE + H_FP)) &&
                        (r_h_cnt <  HW'(H_ACTIVE + H_FP + H_SYNC)));
        w_vsync     = !((r_v_cnt >= VW'(V_ACTIVE + V_FP)) &&
                        (r_v_cnt <  VW'(V_ACTIVE + V_FP + V_SYNC)));
        w_vblank    = (r_v_cnt >= VW'(V_ACTIVE));
        // index is parked at 0 outside the active area so it never runs off the buffer
        w_x         = w_video_on ? XW'(r_h_cnt) : '0;
        w_pix_bit   = w_video_on && r_line_buf[w_x];
        w_v_inc     = {1'b0, r_v_cnt} + VW1'(1);
        // the last blank line fetches row 0 for the upcoming frame
        w_fetch_req = (w_v_inc < VW1'(V_ACTIVE)) || w_v_last;
        w_next_row  = w_v_last ? '0 : w_v_inc;
    end

    // Raster counters and registered video outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_h_cnt       <= '0;
            r_v_cnt       <= VW'(V_TOTAL - 1);
            r_pixel       <= 1'b0;
            r_hsync       <= 1'b1;
            r_vsync       <= 1'b1;
            r_video_on    <= 1'b0;
            r_vblank      <= 1'b1;
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= pix_en && w_h_last && w_v_last;
            if (pix_en) begin
                r_pixel    <= w_pix_bit;
                r_hsync    <= w_hsync;
                r_vsync    <= w_vsync;
                r_video_on <= w_video_on;
                r_vblank   <= w_vblank;
                if (w_h_last) begin
                    r_h_cnt <= '0;
                    r_v_cnt <= w_v_last ? '0 : (r_v_cnt + VW'(1));
                end else begin
                    r_h_cnt <= r_h_cnt + HW'(1);
                end
            end
        end
    end

    // Fetch FSM: state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_lat     <= '0;
            r_rd_en   <= 1'b0;
            r_rd_addr <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_lat     <= w_lat_nxt;
            r_rd_en   <= w_rd_en_nxt;
            r_rd_addr <= w_rd_addr_nxt;
        end
    end

    // Fetch FSM: next state and request/capture controls
    always_comb begin
        w_state_nxt   = r_state;
        w_lat_nxt     = r_lat;
        w_rd_en_nxt   = 1'b0;
        w_rd_addr_nxt = r_rd_addr;
        w_capture     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (pix_en && (r_h_cnt == HW'(H_ACTIVE)) && w_fetch_req) begin
                    w_state_nxt   = S_ISSUE;
                    w_rd_en_nxt   = 1'b1;
                    w_rd_addr_nxt = AW'(w_next_row);
                end
            end
            S_ISSUE: begin
                w_state_nxt = S_WAIT;
                w_lat_nxt   = LW'(RD_LATENCY);
            end
            S_WAIT: begin
                // counter hits 0 on this edge, which lands RD_LATENCY clks after the request
                if (r_lat <= LW'(1)) begin
                    w_capture   = 1'b1;
                    w_lat_nxt   = '0;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_lat_nxt = r_lat - LW'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Row double buffer: capture into fetch_buf, swap at end of line
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_buf   <= '0;
            r_fetch_valid <= 1'b0;
            r_line_buf    <= '0;
        end else begin
            if (pix_en && w_h_last) begin
                // an underrun blanks the line instead of stalling the raster
                r_line_buf    <= r_fetch_valid ? r_fetch_buf : '0;
                r_fetch_valid <= 1'b0;
            end
            if (w_capture) begin
                r_fetch_buf   <= from_vram_read;
                r_fetch_valid <= 1'b1;
            end
        end
    end

    assign vram_rd_addr = r_rd_addr;
    assign vram_rd_en   = r_rd_en;
    assign pixel        = r_pixel;
    assign hsync        = r_hsync;
    assign vsync        = r_vsync;
    assign video_on     = r_video_on;
    assign vblank       = r_vblank;
    assign frame_start  = r_frame_start;

endmodule

// File: tb/tb_vram_scanout.sv
// Directed bench for vram_scanout with a shortened vertical raster so whole
// frames fit in the run. A latency-2 VRAM model returns row r = {640{r[0]}},
// except row 5 which has only bit 3 set; one row can be made to answer late.
module tb_vram_scanout;

    localparam int HA  = 640;
    localparam int HT  = 800;
    localparam int VA  = 8;
    localparam int VFP = 2;
    localparam int VS  = 2;
    localparam int VBP = 3;
    localparam int VT  = VA + VFP + VS + VBP;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         pix_en = 1'b0;
    logic [8:0]   vram_rd_addr;
    logic         vram_rd_en;
    logic [639:0] from_vram_read;
    logic         pixel;
    logic         hsync;
    logic         vsync;
    logic         video_on;
    logic         vblank;
    logic         frame_start;

    vram_scanout #(
        .H_ACTIVE(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .RD_LATENCY(2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .pix_en         (pix_en),
        .vram_rd_addr   (vram_rd_addr),
        .vram_rd_en     (vram_rd_en),
        .from_vram_read (from_vram_read),
        .pixel          (pixel),
        .hsync          (hsync),
        .vsync          (vsync),
        .video_on       (video_on),
        .vblank         (vblank),
        .frame_start    (frame_start)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;
    int late_row = -1;

    function automatic logic [639:0] row_data(input int r);
        logic [639:0] d;
        d = '0;
        if (r == 5) d[3] = 1'b1;
        else if (r % 2 == 1) d = '1;
        return d;
    endfunction

    // VRAM model: request seen on a clk edge, data valid two clks later
    logic p1_v = 1'b0, p2_v = 1'b0, p3_v = 1'b0;
    int   p1_r = 0, p2_r = 0, p3_r = 0;
    always @(posedge clk) begin
        p1_v <= vram_rd_en;
        p1_r <= int'(vram_rd_addr);
        p2_v <= p1_v;
        p2_r <= p1_r;
        p3_v <= p2_v;
        p3_r <= p2_r;
    end
    always @* begin
        if (p2_v && p2_r != late_row)      from_vram_read = row_data(p2_r);
        else if (p3_v && p3_r == late_row) from_vram_read = row_data(p3_r);
        else                               from_vram_read = '0;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // expected-state of the bench
    int         q = 0;
    logic [8:0] exp_addr = '0;
    logic [4:0] exp_vid = 5'b01101;
    int         fs_count = 0;
    int         rd_count = 0;

    function automatic logic fetch_req(input int v);
        return (v + 1 < VA) || (v == VT - 1);
    endfunction

    function automatic logic line_bit(input int v, input int h);
        logic [639:0] d;
        if (v == late_row) return 1'b0;
        d = row_data(v);
        return d[h];
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        pix_en = 1'b1;
        @(posedge clk); #1;
        check("rst_pixel",       32'(pixel),        32'd0);
        check("rst_hsync",       32'(hsync),        32'd1);
        check("rst_vsync",       32'(vsync),        32'd1);
        check("rst_video_on",    32'(video_on),     32'd0);
        check("rst_vblank",      32'(vblank),       32'd1);
        check("rst_frame_start", 32'(frame_start),  32'd0);
        check("rst_rd_en",       32'(vram_rd_en),   32'd0);
        check("rst_rd_addr",     32'(vram_rd_addr), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        pix_en = 1'b0;
        q = 0;
        exp_addr = '0;
        exp_vid = 5'b01101;
    endtask

    // Run nclk clocks with pix_en on every div-th clk, checking every clk
    task automatic run(input int nclk, input int div);
        for (int i = 0; i < nclk; i++) begin
            logic pe, efs, erd, vo, px, hs, vs, vb;
            int h, v;
            pe = ((i % div) == 0);
            pix_en = pe;
            @(posedge clk); #1;
            efs = 1'b0;
            erd = 1'b0;
            if (pe) begin
                h  = q % HT;
                v  = (VT - 1 + q / HT) % VT;
                vo = (h < HA) && (v < VA);
                px = vo ? line_bit(v, h) : 1'b0;
                hs = !(h >= 656 && h < 752);
                vs = !(v >= VA + VFP && v < VA + VFP + VS);
                vb = (v >= VA);
                exp_vid = {px, hs, vs, vo, vb};
                efs = (h == HT - 1) && (v == VT - 1);
                if (h == HA && fetch_req(v)) begin
                    erd = 1'b1;
                    exp_addr = 9'(v == VT - 1 ? 0 : v + 1);
                end
                q++;
            end
            check($sformatf("outs q=%0d", q - 1),
                  32'({pixel, hsync, vsync, video_on, vblank, frame_start, vram_rd_en, vram_rd_addr}),
                  32'({exp_vid, efs, erd, exp_addr}));
            if (frame_start) fs_count++;
            if (vram_rd_en) rd_count++;
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);

        // continuous pix_en over a full frame plus the next wrap
        do_reset();
        fs_count = 0;
        rd_count = 0;
        run(13000, 1);
        check("frame_start_count", 32'(fs_count), 32'd2);
        check("fetch_count",       32'(rd_count), 32'd9);

        // pix_en every 4th clk: same sequence, each value held 4 clks
        do_reset();
        run(4 * HT * 3, 4);

        // reset during the WAIT of the row-4 fetch
        do_reset();
        run(4 * HT + HA + 1, 1);
        run(1, 1);
        do_reset();
        run(3 * HT, 1);

        // row 2 answers late: the capture sees no data and line 2 is black
        late_row = 2;
        do_reset();
        run(4 * HT, 1);
        late_row = -1;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
